// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and constants for the register-file FIFO clients.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_fifo_data_w = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        POP  = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// ============================================================================
// Module      : stream_buf2
// Description : Two-entry in-order valid/ready buffer; head word on data.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = c_fifo_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_slot0;
    logic [DATA_W-1:0] r_slot1;
    logic [1:0]        r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = (r_count != 2'd0) && ready;
    // A push into a full buffer is only accepted when the head leaves this cycle.
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    // Unused slots are kept at zero so the head reads 0 whenever empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_slot0 <= data_in;
                    else                 r_slot1 <= data_in;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_slot1 <= '0;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= data_in;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (r_count != 2'd0);
    assign data  = r_slot0;
    assign count = r_count;

endmodule : stream_buf2
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Reads the register-file FIFO and re-presents words as a stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = c_fifo_data_w,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic              fifo_wr_fifo,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_fifo,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  pop_count,
    output logic              busy
);

    state_t           r_state;
    state_t           w_next;
    logic             r_arm_ok;
    logic [CNT_W-1:0] r_pop_count;
    logic [1:0]       w_buf_count;
    logic             w_room;
    logic             w_capture;

    assign w_room    = (w_buf_count < 2'd2);
    // The empty flag is only current in POP; writer activity in ARM voids the read.
    assign w_capture = (r_state == POP) && r_arm_ok && !fifo_empty;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en && !fifo_empty && w_room) w_next = ARM;
            ARM:     w_next = POP;
            POP:     w_next = GAP;
            GAP:     w_next = (en && w_room) ? ARM : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_arm_ok    <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ARM) r_arm_ok <= !fifo_wr_fifo;
            if (w_capture)      r_pop_count <= r_pop_count + CNT_W'(1);
        end
    end

    stream_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_capture),
        .data_in (fifo_rd_data),
        .ready   (m_ready),
        .valid   (m_valid),
        .data    (m_data),
        .count   (w_buf_count)
    );

    assign fifo_rd_fifo = (r_state == ARM) || (r_state == POP);
    assign pop_count    = r_pop_count;
    assign busy         = (r_state != IDLE) || (w_buf_count != 2'd0);

endmodule : fifo_stream_reader
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed bench with a behavioural register-file FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        fifo_empty;
    logic        fifo_wr_fifo = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_fifo;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic [15:0] pop_count;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] q_out[$];

    // FIFO model: registered empty, read mode entered after rd with no write
    logic [7:0] mem [0:15];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    logic       read_mode = 1'b0;
    logic       empty_r = 1'b1;

    always @(posedge clk) begin
        if (fifo_wr_fifo) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
        end
        if (read_mode && fifo_rd_fifo && !empty_r) rp <= rp + 4'd1;
        read_mode <= fifo_rd_fifo && !fifo_wr_fifo;
        empty_r   <= (wp == rp);
    end

    assign fifo_empty   = empty_r;
    assign fifo_rd_data = mem[rp];

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_W (8),
        .CNT_W  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_wr_fifo (fifo_wr_fifo),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_fifo (fifo_rd_fifo),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .pop_count    (pop_count),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) q_out.push_back(m_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        fifo_wr_fifo = 1'b1;
        wr_data      = d;
        step(1);
        fifo_wr_fifo = 1'b0;
    endtask

    task automatic check_words(input string tag, input logic [7:0] exp[$]);
        check({tag, "_n"}, q_out.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q_out.size()) check($sformatf("%s_w%0d", tag, i), q_out[i], exp[i]);
        end
    endtask

    initial begin
        logic [9:0] rd_pat;
        logic [9:0] v_pat;
        logic [7:0] gap_data;

        // Reset applied between edges with random enables
        #1;
        rst_n   = 1'b0;
        en      = 1'($urandom);
        m_ready = 1'($urandom);
        #1;
        check("rst_rd",    fifo_rd_fifo, 0);
        check("rst_valid", m_valid,      0);
        check("rst_data",  m_data,       0);
        check("rst_cnt",   pop_count,    0);
        check("rst_busy",  busy,         0);
        en = 1'b0;
        m_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Drain three words at full rate
        fifo_write(8'hA1);
        fifo_write(8'hB2);
        fifo_write(8'hC3);
        step(2);
        q_out.delete();
        en = 1'b1;
        gap_data = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_pat = {rd_pat[8:0], fifo_rd_fifo};
            v_pat  = {v_pat[8:0], m_valid};
            if (i == 3) gap_data = m_data;
        end
        en = 1'b0;
        step(3);
        check("drain_rdpat", rd_pat, 10'b0110110110);
        check("drain_vpat",  v_pat,  10'b0001001001);
        check("drain_gap",   gap_data, 8'hA1);
        check_words("drain", '{8'hA1, 8'hB2, 8'hC3});
        check("drain_cnt",  pop_count, 3);
        check("drain_rd0",  fifo_rd_fifo, 0);
        check("drain_busy", busy, 0);
        check("drain_ptr",  rp, wp);

        // Backpressure: only two words fit
        m_ready = 1'b0;
        fifo_write(8'h31);
        fifo_write(8'h32);
        fifo_write(8'h33);
        fifo_write(8'h34);
        step(2);
        q_out.delete();
        en = 1'b1;
        step(15);
        check("bp_cnt",   pop_count, 5);
        check("bp_valid", m_valid, 1);
        check("bp_head",  m_data, 8'h31);
        check("bp_rd",    fifo_rd_fifo, 0);
        check("bp_busy",  busy, 1);
        m_ready = 1'b1;
        step(15);
        en = 1'b0;
        step(5);
        check_words("bp", '{8'h31, 8'h32, 8'h33, 8'h34});
        check("bp_cnt2", pop_count, 7);

        // Writer collides with ARM
        fifo_write(8'h11);
        step(2);
        q_out.delete();
        en = 1'b1;
        step(1);
        fifo_wr_fifo = 1'b1;
        wr_data      = 8'h22;
        @(negedge clk);
        check("col_arm_rd", fifo_rd_fifo, 1);
        step(1);
        fifo_wr_fifo = 1'b0;
        @(negedge clk);
        check("col_pop_cnt", pop_count, 7);
        step(1);
        @(negedge clk);
        check("col_gap_valid", m_valid, 0);
        check("col_gap_cnt",   pop_count, 7);
        step(20);
        en = 1'b0;
        step(5);
        check_words("col", '{8'h11, 8'h22});
        check("col_cnt", pop_count, 9);
        check("col_ptr", rp, wp);

        // Single last word with enable held
        fifo_write(8'h5A);
        step(2);
        q_out.delete();
        en = 1'b1;
        step(20);
        en = 1'b0;
        step(5);
        check_words("last", '{8'h5A});
        check("last_cnt", pop_count, 10);
        check("last_ptr", rp, wp);

        // Reset asserted in the middle of POP
        fifo_write(8'h77);
        fifo_write(8'h88);
        step(2);
        q_out.delete();
        en = 1'b1;
        step(2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_rd",    fifo_rd_fifo, 0);
        check("mrst_valid", m_valid, 0);
        check("mrst_data",  m_data, 0);
        check("mrst_cnt",   pop_count, 0);
        check("mrst_busy",  busy, 0);
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_idle_rd",   fifo_rd_fifo, 0);
        check("mrst_idle_busy", busy, 0);
        step(1);
        en = 1'b1;
        step(20);
        en = 1'b0;
        step(5);
        check_words("mrst", '{8'h77, 8'h88});
        check("mrst_cnt2", pop_count, 2);
        check("mrst_ptr",  rp, wp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_stream_reader
`default_nettype wire
